// File: rtl/common_types_pkg.sv
// Shared types for the RAM path.
//   word_t       32-bit data word.
//   ram_state_t  sequencer progress as seen by the memory controller.
//                Encoding 3 is unused and is treated as RAM_FREE.
//   merge_lanes  replaces the byte lanes selected by a 4-bit mask.
package common_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RAM_FREE = 2'd0,
      RAM_BUSY = 2'd1,
      RAM_DONE = 2'd2
   } ram_state_t;

   function automatic word_t merge_lanes(input word_t old_w, input word_t new_w,
                                         input logic [3:0] lanes);
      word_t res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port word array with byte-lane write mask.
//   clk    rising-edge clock
//   we     byte-lane write enables (lane i = wdata[8i+7:8i])
//   re     capture the addressed word into rdata at this edge
//   widx   word index
//   wdata  write data
//   rdata  registered read data; write-first, so a simultaneous write and
//          read returns the merged post-write word
// Contents are not reset.
module sram_sp
   import common_types_pkg::*;
#(
   parameter int DEPTH = 4096
) (
   input  logic                     clk,
   input  logic [3:0]               we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] widx,
   input  word_t                    wdata,
   output word_t                    rdata
);

   word_t mem [DEPTH];
   word_t merged;

   always_comb begin
      merged = merge_lanes(mem[widx], wdata, we);
   end

   always_ff @(posedge clk) begin
      if (|we) mem[widx] <= merged;
      if (re)  rdata     <= merged;
   end

endmodule

// File: rtl/ram_sequencer.sv
// Sequences single-port RAM accesses for the memory controller.
//   clk    rising-edge clock
//   nrst   synchronous, active-high reset
//   ren    read request (level, held until RAM_DONE)
//   wen    byte-lane write enables; nonzero = write request (wins over ren)
//   addr   byte address; word index = addr[$clog2(DEPTH)+1:2]
//   store  write data
//   load   read (or post-write) data, valid in RAM_DONE, held otherwise
//   state  current sequencer state
//
// state    | meaning
// RAM_FREE | idle, accepting a request
// RAM_BUSY | wait states; request must stay stable or the access aborts
// RAM_DONE | access committed, load valid; one cycle only
module ram_sequencer
   import common_types_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4096,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              ren,
   input  logic [3:0]        wen,
   input  logic [ADDR_W-1:0] addr,
   input  word_t             store,
   output word_t             load,
   output ram_state_t        state
);

   localparam int         IDX_W    = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   ram_state_t        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [3:0]        lat_wen_q;
   logic              lat_ren_q;
   word_t             lat_store_q;
   logic              load_vld_q;

   logic              req;
   logic              req_same;
   logic              latch_en;
   logic              commit;
   logic [3:0]        ram_we;
   logic              ram_re;
   word_t             ram_rdata;

   assign req      = ren | (|wen);
   assign req_same = req && (addr == lat_addr_q) && (wen == lat_wen_q)
                     && (ren == lat_ren_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      latch_en = 1'b0;
      commit   = 1'b0;
      case (state_q)
         RAM_BUSY: begin
            if (!req_same) begin
               state_d = RAM_FREE;
               cnt_d   = 4'd0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               commit  = 1'b1;
               state_d = RAM_DONE;
            end
         end
         RAM_DONE: begin
            state_d = RAM_FREE;
         end
         default: begin
            if (req) begin
               latch_en = 1'b1;
               cnt_d    = CNT_INIT;
               state_d  = RAM_BUSY;
            end
         end
      endcase
   end

   // Reset wins over a commit falling on the same edge.
   assign ram_we = (commit && !nrst) ? lat_wen_q : 4'd0;
   assign ram_re = commit && !nrst;

   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q     <= RAM_FREE;
         cnt_q       <= 4'd0;
         lat_addr_q  <= '0;
         lat_wen_q   <= 4'd0;
         lat_ren_q   <= 1'b0;
         lat_store_q <= '0;
         load_vld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch_en) begin
            lat_addr_q  <= addr;
            lat_wen_q   <= wen;
            lat_ren_q   <= ren;
            lat_store_q <= store;
         end
         if (commit) load_vld_q <= 1'b1;
      end
   end

   sram_sp #(
      .DEPTH (DEPTH)
   ) u_sram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .widx  (lat_addr_q[IDX_W+1:2]),
      .wdata (lat_store_q),
      .rdata (ram_rdata)
   );

   // The array's read register has no reset; load reads as zero until the
   // first commit after reset.
   assign load  = load_vld_q ? ram_rdata : '0;
   assign state = state_q;

endmodule

// File: tb/tb_ram_sequencer.sv
module tb_ram_sequencer;
   import common_types_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 4096;
   localparam int LAT    = 2;

   logic        clk   = 1'b0;
   logic        nrst  = 1'b1;
   logic        ren   = 1'b0;
   logic [3:0]  wen   = 4'd0;
   logic [31:0] addr  = 32'd0;
   word_t       store = 32'd0;
   word_t       load;
   ram_state_t  state;

   ram_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk   (clk),
      .nrst  (nrst),
      .ren   (ren),
      .wen   (wen),
      .addr  (addr),
      .store (store),
      .load  (load),
      .state (state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase counts cycles since acceptance
   // (0 idle, 1..LAT waiting, LAT+1 done).
   int          m_phase   = 0;
   bit          m_started = 0;
   logic [31:0] m_addr    = 0;
   logic [3:0]  m_wen     = 0;
   logic        m_ren     = 0;
   word_t       m_store   = 0;
   word_t       m_mem [int];
   word_t       m_load    = 0;
   bit          m_known   = 1;

   task automatic model_commit();
      int    idx;
      word_t w;
      idx = int'((m_addr >> 2) % DEPTH);
      if (m_wen != 4'd0) begin
         if (m_mem.exists(idx)) begin
            w = m_mem[idx];
            for (int i = 0; i < 4; i++)
               if (m_wen[i]) w[8*i +: 8] = m_store[8*i +: 8];
            m_mem[idx] = w;
         end else if (m_wen == 4'hF) begin
            m_mem[idx] = m_store;
         end
      end
      if (m_mem.exists(idx)) begin
         m_load  = m_mem[idx];
         m_known = 1;
      end else begin
         m_known = 0;
      end
   endtask

   always @(posedge clk) begin
      m_started = 1;
      if (nrst) begin
         m_phase = 0; m_load = 0; m_known = 1;
         m_addr = 0; m_wen = 0; m_ren = 0; m_store = 0;
      end else if (m_phase == 0) begin
         if (ren || wen != 4'd0) begin
            m_addr = addr; m_wen = wen; m_ren = ren; m_store = store;
            m_phase = 1;
         end
      end else if (m_phase <= LAT) begin
         if (!(ren || wen != 4'd0) || addr != m_addr || wen != m_wen || ren != m_ren)
            m_phase = 0;
         else if (m_phase == LAT) begin
            model_commit();
            m_phase = LAT + 1;
         end else
            m_phase++;
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      ram_state_t exp_st;
      if (m_started) begin
         exp_st = (m_phase == 0) ? RAM_FREE : (m_phase <= LAT) ? RAM_BUSY : RAM_DONE;
         chk("state", 32'(state), 32'(exp_st));
         if (m_known) chk("load", load, m_load);
      end
   end

   // Drives a request (called at a falling edge) and waits for RAM_DONE.
   task automatic xact(input logic r, input logic [3:0] w, input logic [31:0] a,
                       input word_t d, output word_t got, output int cyc);
      ren = r; wen = w; addr = a; store = d;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (state !== RAM_DONE && cyc < 20);
      chk("done_reached", 32'(state), 32'(RAM_DONE));
      got = load;
      ren = 1'b0; wen = 4'd0;
   endtask

   initial begin
      word_t got;
      int    cyc;

      // reset held two cycles with a read pending
      ren = 1'b1; addr = 32'h100;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state), 32'(RAM_FREE));
      chk("rst_load", load, 32'd0);
      nrst = 1'b0;
      @(negedge clk);
      chk("first_busy", 32'(state), 32'(RAM_BUSY));
      cyc = 0;
      while (state !== RAM_DONE && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      ren = 1'b0;
      @(negedge clk);

      // full write then read
      xact(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, got, cyc);
      chk("wr_latency", cyc, LAT + 1);
      chk("wr_load", got, 32'hDEADBEEF);
      @(negedge clk);
      chk("done_one_cycle", 32'(state), 32'(RAM_FREE));
      xact(1'b1, 4'h0, 32'h10, 32'h0, got, cyc);
      chk("rd_latency", cyc, LAT + 1);
      chk("rd_data", got, 32'hDEADBEEF);

      // byte mask, back to back
      xact(1'b0, 4'hF, 32'h50, 32'h11223344, got, cyc);
      chk("b2b_latency", cyc, LAT + 2);
      xact(1'b0, 4'b0100, 32'h50, 32'h00AA0000, got, cyc);
      chk("mask_postwrite", got, 32'h11AA3344);
      xact(1'b1, 4'h0, 32'h52, 32'h0, got, cyc);
      chk("mask_read", got, 32'h11AA3344);

      // abort by address change in the second wait cycle
      xact(1'b0, 4'hF, 32'h20, 32'h55AA55AA, got, cyc);
      @(negedge clk);
      ren = 1'b0; wen = 4'hF; addr = 32'h20; store = 32'hCAFEF00D;
      @(negedge clk);
      chk("abort_busy1", 32'(state), 32'(RAM_BUSY));
      @(negedge clk);
      chk("abort_busy2", 32'(state), 32'(RAM_BUSY));
      addr = 32'h24;
      @(negedge clk);
      chk("abort_free", 32'(state), 32'(RAM_FREE));
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (state !== RAM_DONE && cyc < 20);
      chk("abort_retry_latency", cyc, LAT + 1);
      wen = 4'd0;
      @(negedge clk);
      xact(1'b1, 4'h0, 32'h20, 32'h0, got, cyc);
      chk("abort_orig_kept", got, 32'h55AA55AA);
      xact(1'b1, 4'h0, 32'h24, 32'h0, got, cyc);
      chk("abort_new_done", got, 32'hCAFEF00D);

      // reset landing on the commit edge
      xact(1'b0, 4'hF, 32'h30, 32'h12345678, got, cyc);
      @(negedge clk);
      ren = 1'b0; wen = 4'hF; addr = 32'h30; store = 32'hFFFFFFFF;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk("rstc_state", 32'(state), 32'(RAM_FREE));
      chk("rstc_load", load, 32'd0);
      nrst = 1'b0; wen = 4'd0;
      @(negedge clk);
      xact(1'b1, 4'h0, 32'h30, 32'h0, got, cyc);
      chk("rstc_no_write", got, 32'h12345678);

      // aliasing and write priority
      xact(1'b0, 4'hF, 32'h4004, 32'hA5A50001, got, cyc);
      xact(1'b1, 4'h0, 32'h0004, 32'h0, got, cyc);
      chk("alias", got, 32'hA5A50001);
      xact(1'b1, 4'hF, 32'h40, 32'h00000077, got, cyc);
      chk("prio_postwrite", got, 32'h00000077);
      xact(1'b1, 4'h0, 32'h40, 32'h0, got, cyc);
      chk("prio_read", got, 32'h00000077);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_sequencer.md
# ram_sequencer

Sequences the single-port instruction/data RAM on behalf of the memory controller. Accepts one read or byte-masked write request at a time, inserts a configurable number of wait states, commits the access to the storage array, and reports progress on `state`. It sits between the memory controller and the `sram_sp` storage array. The memory controller gates the CPU's `iwait`/`dwait` on `state == RAM_DONE`.

## Interface
- `ADDR_W`, default 32: request address width (byte address).
- `DEPTH`, default 4096: array depth in 32-bit words; power of two.
- `LAT`, default 2: wait-state count; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `nrst`  in  1  reset; synchronous, active-high.
- `ren`  in  1  read request; level, held until `RAM_DONE` is seen.
- `wen`  in  4  byte-lane write enables; nonzero means write request.
- `addr`  in  ADDR_W  byte address of the request.
- `store`  in  32  write data; lane i is `store[8i+7:8i]`.
- `load`  out  32  read data; valid while `state == RAM_DONE`.
- `state`  out  `ram_state_t`  current sequencer state.

## Operation
- **Request.** A request is present when `ren` is high or `|wen` is set. If both are present, write wins and the read is ignored for that transaction.
- **Word index.** `addr[$clog2(DEPTH)+1:2]`.
  - `addr[1:0]` is ignored.
  - Upper address bits are ignored, so addresses alias modulo `DEPTH*4`.
- **RAM_FREE.**
  - No request: stay.
  - Request present: latch `addr`, `wen`, `store` and op type; load `cnt = LAT-1`; go to `RAM_BUSY`.
- **RAM_BUSY.**
  - Abort: if the live request differs from the latched one (`addr`, `wen`, or `ren` changed, or the request dropped), go to `RAM_FREE`. No array access happens and `cnt` is cleared.
  - Otherwise, if `cnt != 0`: `cnt <= cnt-1`.
  - Otherwise (`cnt == 0`): commit at this edge and go to `RAM_DONE`.
    - Write commit: updates the enabled byte lanes only.
    - Read commit: captures the addressed word into `load`.
    - Write commit also captures the post-write word into `load`.
- **RAM_DONE.** Lasts exactly one cycle, then always goes to `RAM_FREE`, regardless of the request lines. A new request is accepted from `RAM_FREE` on the following edge.
- **`load`.** Holds its last value outside `RAM_DONE`.
- **Array contents.** Never cleared by reset.
- **Reset** (`nrst` high at an edge):
  - `state <= RAM_FREE`; `cnt <= 0`; `load <= 0`; latched request registers `<= 0`.
  - Overrides any commit scheduled for that edge: no write occurs.

## Timing
- Request first sampled in `RAM_FREE` at edge 0 → `RAM_BUSY` for LAT cycles → `RAM_DONE` visible in cycle LAT+1. With LAT=2, `RAM_DONE` is in cycle 3.
- Back-to-back requests: one idle `RAM_FREE` cycle between transactions. Throughput is one access per LAT+2 cycles.
- `state` and `load` are registered outputs; there is no combinational path from inputs.
- Abort takes effect at the next edge. The new request is accepted from `RAM_FREE` one edge later.
- A request arriving in the same cycle reset deasserts is sampled at the next edge.

## Structure
- `ram_state_t` lives in `common_types_pkg`: 2-bit enum with `RAM_FREE`=0, `RAM_BUSY`=1, `RAM_DONE`=2; 3 is unused and decodes to `RAM_FREE`. `word_t` (32-bit) also lives there.
- One sub-module, `sram_sp`:
  - Parameter: `DEPTH`.
  - Ports: `clk`, `we[3:0]`, `re`, `widx`, `wdata`, `rdata`.
  - Synchronous write with byte mask; synchronous read with write-first semantics.
- The sequencer FSM, wait-state counter and request latch stay in `ram_sequencer`.

## Test plan
- **Reset:** hold `nrst` for 2 cycles with `ren=1` → `state=RAM_FREE`, `load=0` throughout; first `RAM_BUSY` appears the cycle after release.
- **Full write then read, LAT=2:**
  - Write `0xDEADBEEF` to `addr 0x10`, `wen=4'hF` → `RAM_DONE` in cycle 3, held one cycle.
  - Read `0x10` → `load=0xDEADBEEF` in its `RAM_DONE` cycle.
- **Byte mask:** word `0x11223344`, write `wen=4'b0100`, `store=0x00AA0000` → readback `0x11AA3344`.
- **Abort:** start a write to `0x20`, change `addr` to `0x24` in the second `RAM_BUSY` cycle → `RAM_FREE` next cycle, `0x20` unchanged; `0x24` completes LAT+1 cycles after its acceptance.
- **Reset at commit edge:** assert `nrst` exactly at the `cnt==0` edge of a write → array word unchanged, `state=RAM_FREE`.
- **Aliasing and priority:**
  - DEPTH=4096: write `addr 0x4004`, read `addr 0x0004` → same data.
  - `ren=1` with `wen=4'hF` → write performed.
